// File: rtl/ofm_port_arbiter.sv
// ofm_port_arbiter: shares the OFM RAM read port (A) and write port (B)
// between the accelerator core, which always wins, and a host requester
// that is served in idle cycles through a valid/ready handshake.
// Host read returns are tracked by a READ_LATENCY-deep tag pipe.
module ofm_port_arbiter #(
    parameter int unsigned OFM_RAM_SIZE = 2378675,
    parameter int unsigned INOUT_WIDTH  = 256,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STALL_CNT_W  = 16,
    localparam int unsigned AW          = $clog2(OFM_RAM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   core_rd_en,
    input  logic [AW-1:0]          core_rd_addr,
    output logic [INOUT_WIDTH-1:0] core_rd_data,
    input  logic                   core_wr_en,
    input  logic [AW-1:0]          core_wr_addr,
    input  logic [INOUT_WIDTH-1:0] core_wr_data,
    input  logic [4:0]             core_wr_size,
    input  logic                   host_rd_req,
    input  logic [AW-1:0]          host_rd_addr,
    output logic                   host_rd_ready,
    output logic [INOUT_WIDTH-1:0] host_rd_data,
    output logic                   host_rd_valid,
    input  logic                   host_wr_req,
    input  logic [AW-1:0]          host_wr_addr,
    input  logic [INOUT_WIDTH-1:0] host_wr_data,
    output logic                   host_wr_ready,
    output logic                   ofm_read_en,
    output logic [AW-1:0]          ofm_addr_a,
    input  logic [INOUT_WIDTH-1:0] ofm_data_in,
    output logic                   write_out_ofm_en,
    output logic [AW-1:0]          ofm_addr_b,
    output logic [INOUT_WIDTH-1:0] ofm_data_out,
    output logic [4:0]             write_ofm_size,
    output logic [2:0]             host_rd_pending,
    output logic [STALL_CNT_W-1:0] host_stall_cnt,
    input  logic                   clr_stats
);

    logic                    rd_accept;
    logic                    stall;
    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic [2:0]              pending_q, pending_d;
    logic [STALL_CNT_W-1:0]  stall_q, stall_d;

    // Port grant and muxing: core has absolute priority, no added latency
    always_comb begin
        host_rd_ready    = ~core_rd_en;
        ofm_read_en      = core_rd_en | host_rd_req;
        ofm_addr_a       = core_rd_en ? core_rd_addr : host_rd_addr;
        core_rd_data     = ofm_data_in;
        host_rd_data     = ofm_data_in;

        host_wr_ready    = ~core_wr_en;
        write_out_ofm_en = core_wr_en | host_wr_req;
        ofm_addr_b       = core_wr_en ? core_wr_addr : host_wr_addr;
        ofm_data_out     = core_wr_en ? core_wr_data : host_wr_data;
        write_ofm_size   = core_wr_en ? core_wr_size : 5'd16;

        rd_accept        = host_rd_req & ~core_rd_en;
        stall            = (host_rd_req & core_rd_en) | (host_wr_req & core_wr_en);
    end

    // Tag pipe next state: shift in 1 for an accepted host read, else 0
    if (READ_LATENCY == 1) begin : g_tag_one
        always_comb begin
            tag_d = rd_accept;
        end
    end else begin : g_tag_multi
        always_comb begin
            tag_d = {tag_q[READ_LATENCY-2:0], rd_accept};
        end
    end

    // Outstanding host reads and saturating stall count, clear wins
    always_comb begin
        pending_d = pending_q;
        case ({rd_accept, host_rd_valid})
            2'b10:   pending_d = pending_q + 3'd1;
            2'b01:   pending_d = pending_q - 3'd1;
            default: pending_d = pending_q;
        endcase

        stall_d = stall_q;
        if (clr_stats) begin
            stall_d = '0;
        end else if (stall && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State registers; reset drops any in-flight host read tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            tag_q     <= tag_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

    assign host_rd_valid   = tag_q[READ_LATENCY-1];
    assign host_rd_pending = pending_q;
    assign host_stall_cnt  = stall_q;

endmodule

// File: tb/tb_ofm_port_arbiter.sv
// Directed bench for ofm_port_arbiter: one instance at READ_LATENCY=1,
// one at READ_LATENCY=3 with a 4-bit stall counter, sharing all inputs.
module tb_ofm_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_rd_en, core_wr_en, host_rd_req, host_wr_req, clr_stats;
    logic [AW-1:0] core_rd_addr, core_wr_addr, host_rd_addr, host_wr_addr;
    logic [DW-1:0] core_wr_data, host_wr_data;
    logic [4:0]    core_wr_size;

    logic [DW-1:0] o1_core_rd_data, o1_host_rd_data, o1_ofm_data_out, o1_ofm_data_in;
    logic          o1_host_rd_ready, o1_host_rd_valid, o1_host_wr_ready, o1_ofm_read_en, o1_write_out_ofm_en;
    logic [AW-1:0] o1_ofm_addr_a, o1_ofm_addr_b;
    logic [4:0]    o1_write_ofm_size;
    logic [2:0]    o1_host_rd_pending;
    logic [15:0]   o1_host_stall_cnt;

    logic [DW-1:0] o3_core_rd_data, o3_host_rd_data, o3_ofm_data_out, o3_ofm_data_in;
    logic          o3_host_rd_ready, o3_host_rd_valid, o3_host_wr_ready, o3_ofm_read_en, o3_write_out_ofm_en;
    logic [AW-1:0] o3_ofm_addr_a, o3_ofm_addr_b;
    logic [4:0]    o3_write_ofm_size;
    logic [2:0]    o3_host_rd_pending;
    logic [3:0]    o3_host_stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ofm_port_arbiter #(.READ_LATENCY(1), .STALL_CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(o1_core_rd_data),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_size(core_wr_size),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_ready(o1_host_rd_ready),
        .host_rd_data(o1_host_rd_data), .host_rd_valid(o1_host_rd_valid),
        .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_ready(o1_host_wr_ready),
        .ofm_read_en(o1_ofm_read_en), .ofm_addr_a(o1_ofm_addr_a), .ofm_data_in(o1_ofm_data_in),
        .write_out_ofm_en(o1_write_out_ofm_en), .ofm_addr_b(o1_ofm_addr_b),
        .ofm_data_out(o1_ofm_data_out), .write_ofm_size(o1_write_ofm_size),
        .host_rd_pending(o1_host_rd_pending), .host_stall_cnt(o1_host_stall_cnt),
        .clr_stats(clr_stats)
    );

    ofm_port_arbiter #(.READ_LATENCY(3), .STALL_CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(o3_core_rd_data),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_wr_size(core_wr_size),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_ready(o3_host_rd_ready),
        .host_rd_data(o3_host_rd_data), .host_rd_valid(o3_host_rd_valid),
        .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_ready(o3_host_wr_ready),
        .ofm_read_en(o3_ofm_read_en), .ofm_addr_a(o3_ofm_addr_a), .ofm_data_in(o3_ofm_data_in),
        .write_out_ofm_en(o3_write_out_ofm_en), .ofm_addr_b(o3_ofm_addr_b),
        .ofm_data_out(o3_ofm_data_out), .write_ofm_size(o3_write_ofm_size),
        .host_rd_pending(o3_host_rd_pending), .host_stall_cnt(o3_host_stall_cnt),
        .clr_stats(clr_stats)
    );

    // RAM content is a fixed function of the address
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {8{10'h2A5, a}};
    endfunction

    // RAM models: 1-cycle and 3-cycle read latency
    logic [DW-1:0] p0, p1, p2;
    always @(posedge clk) begin
        if (o1_ofm_read_en) o1_ofm_data_in <= word(o1_ofm_addr_a);
        p0 <= word(o3_ofm_addr_a);
        p1 <= p0;
        p2 <= p1;
    end
    assign o3_ofm_data_in = p2;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        core_rd_en = 0; core_wr_en = 0; host_rd_req = 0; host_wr_req = 0; clr_stats = 0;
        core_rd_addr = '0; core_wr_addr = '0; host_rd_addr = '0; host_wr_addr = '0;
        core_wr_data = '0; host_wr_data = '0; core_wr_size = '0;
        #12;
        chk("rst_valid1", o1_host_rd_valid, 0);
        chk("rst_pend1", o1_host_rd_pending, 0);
        chk("rst_stall1", o1_host_stall_cnt, 0);
        chk("rst_valid3", o3_host_rd_valid, 0);
        chk("rst_pend3", o3_host_rd_pending, 0);
        #5 rst_n = 1'b1;
        tick();

        // Core-only reads at 0..15
        for (int i = 0; i < 16; i++) begin
            core_rd_en = 1; core_rd_addr = AW'(i);
            #1;
            chk("core_addr_a", o1_ofm_addr_a, AW'(i));
            chk("core_rd_en", o1_ofm_read_en, 1);
            chk("core_hready", o1_host_rd_ready, 0);
            tick();
            chk("core_rd_data", o1_core_rd_data, word(AW'(i)));
            chk("core_hvalid", o1_host_rd_valid, 0);
        end
        core_rd_en = 0;
        chk("core_stall", o1_host_stall_cnt, 0);

        // Host read of 100 with core idle
        host_rd_req = 1; host_rd_addr = 100;
        #1;
        chk("h100_ready", o1_host_rd_ready, 1);
        chk("h100_addr_a", o1_ofm_addr_a, 100);
        chk("h100_rd_en", o1_ofm_read_en, 1);
        tick();
        host_rd_req = 0;
        chk("h100_valid", o1_host_rd_valid, 1);
        chk("h100_data", o1_host_rd_data, word(100));
        chk("h100_pend1", o1_host_rd_pending, 1);
        tick();
        chk("h100_valid0", o1_host_rd_valid, 0);
        chk("h100_pend0", o1_host_rd_pending, 0);

        // Host read stalled 5 cycles behind core reads
        core_rd_en = 1; core_rd_addr = 5; host_rd_req = 1; host_rd_addr = 200;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", o1_host_rd_ready, 0);
            chk("stall_addr_a", o1_ofm_addr_a, 5);
            tick();
            chk("stall_valid", o1_host_rd_valid, 0);
        end
        chk("stall_cnt5", o1_host_stall_cnt, 5);
        core_rd_en = 0;
        #1;
        chk("h200_ready", o1_host_rd_ready, 1);
        chk("h200_addr_a", o1_ofm_addr_a, 200);
        tick();
        host_rd_req = 0;
        chk("h200_valid", o1_host_rd_valid, 1);
        chk("h200_data", o1_host_rd_data, word(200));
        chk("h200_stall", o1_host_stall_cnt, 5);
        tick();

        // Core write beats host write, host follows with full size
        core_wr_en = 1; core_wr_addr = 7; core_wr_size = 3; core_wr_data = {8{32'hC0DE0007}};
        host_wr_req = 1; host_wr_addr = 9; host_wr_data = {8{32'h80570009}};
        #1;
        chk("cw_addr_b", o1_ofm_addr_b, 7);
        chk("cw_size", o1_write_ofm_size, 3);
        chk("cw_data", o1_ofm_data_out, {8{32'hC0DE0007}});
        chk("cw_hready", o1_host_wr_ready, 0);
        chk("cw_en", o1_write_out_ofm_en, 1);
        tick();
        core_wr_en = 0;
        #1;
        chk("hw_addr_b", o1_ofm_addr_b, 9);
        chk("hw_size", o1_write_ofm_size, 16);
        chk("hw_data", o1_ofm_data_out, {8{32'h80570009}});
        chk("hw_ready", o1_host_wr_ready, 1);
        chk("hw_en", o1_write_out_ofm_en, 1);
        tick();
        host_wr_req = 0;
        chk("wr_stall6", o1_host_stall_cnt, 6);

        // Both ports stalled in one cycle count once
        core_rd_en = 1; core_wr_en = 1; host_rd_req = 1; host_wr_req = 1;
        tick();
        core_rd_en = 0; core_wr_en = 0; host_rd_req = 0; host_wr_req = 0;
        chk("dual_stall", o1_host_stall_cnt, 7);

        // Host read and host write accepted together
        host_rd_req = 1; host_rd_addr = 300; host_wr_req = 1; host_wr_addr = 11;
        #1;
        chk("both_rready", o1_host_rd_ready, 1);
        chk("both_wready", o1_host_wr_ready, 1);
        chk("both_addr_a", o1_ofm_addr_a, 300);
        chk("both_addr_b", o1_ofm_addr_b, 11);
        tick();
        host_rd_req = 0; host_wr_req = 0;
        chk("both_valid", o1_host_rd_valid, 1);
        chk("both_data", o1_host_rd_data, word(300));
        chk("both_stall", o1_host_stall_cnt, 7);
        tick();

        // READ_LATENCY=3: back-to-back host reads 1,2,3
        clr_stats = 1;
        tick();
        clr_stats = 0;
        chk("l3_clr", o3_host_stall_cnt, 0);
        host_rd_req = 1; host_rd_addr = 1;
        tick();
        chk("l3_p1", o3_host_rd_pending, 1);
        chk("l3_v1", o3_host_rd_valid, 0);
        host_rd_addr = 2;
        tick();
        chk("l3_p2", o3_host_rd_pending, 2);
        chk("l3_v2", o3_host_rd_valid, 0);
        host_rd_addr = 3;
        tick();
        host_rd_req = 0;
        chk("l3_p3", o3_host_rd_pending, 3);
        chk("l3_v3", o3_host_rd_valid, 1);
        chk("l3_d1", o3_host_rd_data, word(1));
        tick();
        chk("l3_p4", o3_host_rd_pending, 2);
        chk("l3_v4", o3_host_rd_valid, 1);
        chk("l3_d2", o3_host_rd_data, word(2));
        tick();
        chk("l3_p5", o3_host_rd_pending, 1);
        chk("l3_v5", o3_host_rd_valid, 1);
        chk("l3_d3", o3_host_rd_data, word(3));
        tick();
        chk("l3_p6", o3_host_rd_pending, 0);
        chk("l3_v6", o3_host_rd_valid, 0);

        // Reset with two host reads in flight
        host_rd_req = 1; host_rd_addr = 40;
        tick();
        host_rd_addr = 41;
        tick();
        host_rd_req = 0;
        chk("inflight_pend", o3_host_rd_pending, 2);
        rst_n = 1'b0;
        #1;
        chk("mrst_pend", o3_host_rd_pending, 0);
        chk("mrst_valid", o3_host_rd_valid, 0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", o3_host_rd_valid, 0);
        end
        chk("post_rst_pend", o3_host_rd_pending, 0);

        // Stall counter saturation and clear priority
        core_rd_en = 1; host_rd_req = 1;
        repeat (20) tick();
        chk("sat_cnt3", o3_host_stall_cnt, 4'hF);
        chk("sat_cnt1", o1_host_stall_cnt, 20);
        clr_stats = 1;
        tick();
        clr_stats = 0;
        chk("clr_cnt3", o3_host_stall_cnt, 0);
        chk("clr_cnt1", o1_host_stall_cnt, 0);
        tick();
        core_rd_en = 0; host_rd_req = 0;
        chk("after_clr3", o3_host_stall_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ofm_port_arbiter.md
# ofm_port_arbiter

Shares the single-read-port / single-write-port OFM RAM between the accelerator core and a host-side requester (debug readback, result DMA, preload of OFM-resident tensors). The accelerator core always has absolute priority on each port, because it has no back-pressure. Host accesses are slotted into idle cycles through a valid/ready handshake. Read data for host accesses is returned with a tagged valid that tracks the fixed RAM read latency. The block sits between the accelerator top level and the OFM RAM ports A (read) and B (write).

## Interface
- OFM_RAM_SIZE, 2378675, OFM RAM depth in words; AW = $clog2(OFM_RAM_SIZE)
- INOUT_WIDTH, 256, RAM word width
- READ_LATENCY, 1, RAM port A cycles from read_en to valid data; legal range 1..4
- STALL_CNT_W, 16, width of host stall counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_rd_en  in  1  core read request; must never be stalled
- core_rd_addr  in  AW  core read address
- core_rd_data  out  INOUT_WIDTH  = ofm_data_in, unconditionally
- core_wr_en  in  1  core write request; must never be stalled
- core_wr_addr  in  AW  core write address
- core_wr_data  in  INOUT_WIDTH  core write data
- core_wr_size  in  5  core write lane count
- host_rd_req  in  1  host read request valid
- host_rd_addr  in  AW  host read address
- host_rd_ready  out  1  host read accepted this cycle
- host_rd_data  out  INOUT_WIDTH  = ofm_data_in
- host_rd_valid  out  1  host_rd_data holds the result of an accepted host read
- host_wr_req  in  1  host write request valid
- host_wr_addr  in  AW  host write address
- host_wr_data  in  INOUT_WIDTH  host write data
- host_wr_ready  out  1  host write accepted this cycle
- ofm_read_en  out  1  RAM port A enable
- ofm_addr_a  out  AW  RAM port A address
- ofm_data_in  in  INOUT_WIDTH  RAM port A data
- write_out_ofm_en  out  1  RAM port B enable
- ofm_addr_b  out  AW  RAM port B address
- ofm_data_out  out  INOUT_WIDTH  RAM port B data
- write_ofm_size  out  5  RAM port B lane count
- host_rd_pending  out  3  number of accepted host reads not yet returned
- host_stall_cnt  out  STALL_CNT_W  saturating count of cycles in which the host was stalled
- clr_stats  in  1  synchronous clear of host_stall_cnt

## Operation
- Read port, combinational grant:
  - host_rd_ready = ~core_rd_en.
  - ofm_read_en = core_rd_en | host_rd_req.
  - ofm_addr_a = core_rd_en ? core_rd_addr : host_rd_addr.
- Write port, combinational grant:
  - host_wr_ready = ~core_wr_en.
  - write_out_ofm_en = core_wr_en | host_wr_req.
  - ofm_addr_b and ofm_data_out select the core or host fields in the same way as port A.
  - write_ofm_size = core_wr_size when the core is granted, else 5'd16 (full word).
- Read and write ports arbitrate independently. A host read and a host write may both be accepted in the same cycle.
- Host read accept = host_rd_req & host_rd_ready. It pushes a 1 into a READ_LATENCY-deep tag shift register. A core read, or an idle cycle, pushes a 0.
- host_rd_valid = output of the tag shift register.
- host_rd_pending:
  - +1 on accept, -1 when host_rd_valid is high, unchanged when both occur in the same cycle.
  - Never exceeds READ_LATENCY.
- Stall counter:
  - host_stall_cnt increments by 1 in each cycle where (host_rd_req & ~host_rd_ready) | (host_wr_req & ~host_wr_ready). A cycle in which both ports stall counts once.
  - Saturates at all-ones.
  - clr_stats has priority over increment: the register reads 0 on the cycle after clr_stats.
- The host must hold its request and its address/data stable until ready is high. The arbiter keeps no request state.

## Timing
- Reset values: the tag pipe is all 0, host_rd_valid = 0, host_rd_pending = 0, host_stall_cnt = 0. Combinational outputs follow their inputs.
- Asserting rst_n low mid-operation discards in-flight host reads. Their host_rd_valid never asserts.
- Grant-to-RAM latency is 0 cycles (combinational). Host read data latency is exactly READ_LATENCY cycles after the accept edge.
- Core timing is bit-identical to a direct RAM connection. The arbiter adds no cycle and no gating to any core access.
- A host access is served on the first cycle with no core activity on that port. No starvation bound is guaranteed.

## Test plan
- Core-only reads at addr 0..15 with the host idle → ofm_addr_a tracks core_rd_addr each cycle, host_rd_valid stays 0, host_stall_cnt = 0.
- Host read of addr 100 with the core idle, READ_LATENCY = 1 → host_rd_ready = 1 in cycle t. In cycle t+1, host_rd_valid = 1 with the RAM word at 100; host_rd_pending goes 1 then 0.
- Host read held for 5 cycles while core_rd_en is high, then the core goes idle → host_stall_cnt = 5. The accept lands in cycle 6 and host_rd_valid asserts READ_LATENCY cycles later.
- Simultaneous core write (addr 7, size 3) and host write (addr 9) → port B carries addr 7 with size 3 and host_wr_ready = 0. Next cycle, with the core idle, port B carries addr 9 with size 16.
- READ_LATENCY = 3 with back-to-back host reads to 1, 2, 3 → host_rd_valid is high in 3 consecutive cycles with matching data, and host_rd_pending peaks at 3.
- Reset asserted with 2 host reads in flight → no host_rd_valid after reset release, host_rd_pending = 0. Separately, driving host_stall_cnt to saturation then pulsing clr_stats → it reads 0.
